// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
// Bytes are queued through a valid/ready handshake and sent back-to-back
// with no idle gap between frames.
// Optional macro UART_TX_PARITY_EN inserts a parity bit (even, or odd when
// ODD_PARITY=1) between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH   = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bitIdx;
  logic [2:0]      w_bitIdxNext;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            w_txNext;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_bitDone;
`ifdef UART_TX_PARITY_EN
  logic            w_parity;
`endif

  assign w_empty      = (r_count == '0);
  assign tx_ready     = (r_count != COUNT_FULL);
  assign w_push       = tx_valid && tx_ready;
  assign w_bitDone    = (r_baud == BAUD_LAST);
  assign w_bitIdxNext = r_bitIdx + 3'd1;
`ifdef UART_TX_PARITY_EN
  assign w_parity     = (^r_shift) ^ (ODD_PARITY != 0);
`endif

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign fifo_count = r_count;

  // FIFO storage: written at the tail on every accepted byte
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Next state, next line level and pop decision; the line is registered so
  // it is computed here from where the FSM is going next
  always_comb begin
    w_nextState = r_state;
    w_txNext    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextState = S_START;
          w_txNext    = 1'b0;
        end
      end
      S_START: begin
        if (w_bitDone) begin
          w_nextState = S_DATA;
          w_txNext    = r_shift[0];
        end else begin
          w_txNext    = 1'b0;
        end
      end
      S_DATA: begin
        if (w_bitDone) begin
          if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_nextState = S_PARITY;
            w_txNext    = w_parity;
`else
            w_nextState = S_STOP;
            w_txNext    = 1'b1;
`endif
          end else begin
            w_txNext    = r_shift[w_bitIdxNext];
          end
        end else begin
          w_txNext      = r_shift[r_bitIdx];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bitDone) begin
          w_nextState = S_STOP;
          w_txNext    = 1'b1;
        end else begin
          w_txNext    = w_parity;
        end
      end
`endif
      S_STOP: begin
        if (w_bitDone) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nextState = S_START;
            w_txNext    = 1'b0;
          end else begin
            w_nextState = S_IDLE;
          end
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State, line, shift register, baud and bit counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_baud   <= '0;
      r_bitIdx <= '0;
    end else begin
      r_state <= w_nextState;
      r_tx    <= w_txNext;
      if (w_pop) begin
        r_shift <= r_mem[r_rdPtr];
      end
      if ((r_state == S_IDLE) || w_bitDone) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BW'(1);
      end
      if ((r_state == S_DATA) && w_bitDone) begin
        r_bitIdx <= w_bitIdxNext;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with CLKS_PER_BIT=4,
// FIFO_DEPTH=4. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int ODD   = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checkCount = 0;
  int errorCount = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .ODD_PARITY(ODD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge
  always #5 clk = ~clk;

  // Expected line level for bit slot idx of a frame carrying d
  function automatic logic expBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^d) ^ (ODD != 0);
`endif
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic rstN);
    tx_valid = valid;
    tx_data  = data;
    reset    = rstN;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed sequence
  initial begin
    logic sawActivity;

    // Reset held low with a byte offered: nothing may be queued
    applyStimulus(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) nextCycle();
    checkOutput("rstTx", 32'(tx), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstCount", 32'(fifo_count), 32'd0);
    checkOutput("rstReady", 32'(tx_ready), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    sawActivity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      if (tx !== 1'b1 || busy !== 1'b0) sawActivity = 1'b1;
    end
    checkOutput("rstNoFrame", 32'(sawActivity), 32'd0);

    // Single byte 0xA5 into an idle block
    applyStimulus(1'b1, 8'hA5, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("a5Count1", 32'(fifo_count), 32'd1);
    checkOutput("a5TxStillHigh", 32'(tx), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      nextCycle();
      if (i == 0) checkOutput("a5Count0", 32'(fifo_count), 32'd0);
      checkOutput("a5Line", 32'(tx), 32'(expBit(8'hA5, i / CPB)));
    end
    checkOutput("a5BusyLastCycle", 32'(busy), 32'd1);
    nextCycle();
    checkOutput("a5BusyDone", 32'(busy), 32'd0);
    checkOutput("a5TxIdle", 32'(tx), 32'd1);

    // Five bytes back-to-back, then junk offered while full
    applyStimulus(1'b1, 8'h00, 1'b1);
    for (int c = 0; c <= 5 * FRAME + 1; c++) begin
      nextCycle();
      if (c >= 1 && c <= 5 * FRAME)
        checkOutput("b2bLine", 32'(tx),
                    32'(expBit(8'((c - 1) / FRAME), ((c - 1) % FRAME) / CPB)));
      if (c == 4) begin
        checkOutput("b2bCountFull", 32'(fifo_count), 32'd4);
        checkOutput("b2bReadyLow", 32'(tx_ready), 32'd0);
      end
      if (c == 20) checkOutput("b2bFullHold", 32'(fifo_count), 32'd4);
      if (c == FRAME + 1) begin
        checkOutput("b2bReadyBack", 32'(tx_ready), 32'd1);
        checkOutput("b2bCount3", 32'(fifo_count), 32'd3);
      end
      if (c == 5 * FRAME) checkOutput("b2bBusyEnd", 32'(busy), 32'd1);
      if (c == 5 * FRAME + 1) begin
        checkOutput("b2bIdle", 32'(busy), 32'd0);
        checkOutput("b2bCount0", 32'(fifo_count), 32'd0);
      end
      if (c < 4) applyStimulus(1'b1, 8'(c + 1), 1'b1);
      else if (c < FRAME - 4) applyStimulus(1'b1, 8'(8'hE0 + c), 1'b1);
      else applyStimulus(1'b0, 8'h00, 1'b1);
    end

    // Reset during a frame with two bytes still queued
    applyStimulus(1'b1, 8'h33, 1'b1);
    for (int c = 0; c <= 16; c++) begin
      nextCycle();
      if (c == 0) applyStimulus(1'b1, 8'h44, 1'b1);
      if (c == 1) applyStimulus(1'b1, 8'h55, 1'b1);
      if (c == 2) applyStimulus(1'b0, 8'h00, 1'b1);
      if (c == 15) begin
        checkOutput("midCount2", 32'(fifo_count), 32'd2);
        checkOutput("midLine", 32'(tx), 32'd0);
        checkOutput("midBusy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
      end
      if (c == 16) begin
        checkOutput("abortTx", 32'(tx), 32'd1);
        checkOutput("abortCount", 32'(fifo_count), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortReady", 32'(tx_ready), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
      end
    end
    sawActivity = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      nextCycle();
      if (tx !== 1'b1 || busy !== 1'b0) sawActivity = 1'b1;
    end
    checkOutput("abortNoFrame", 32'(sawActivity), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-serial UART transmitter (8N1, LSB first) driving the processor's `tx` pin.
- Complements the existing `rx` input path.
- Bytes pushed by the debug/loader logic through a valid/ready handshake are buffered in a small FIFO.
- Bytes are serialized back-to-back at a fixed bit period derived from the system clock.

Parameters:
- CLKS_PER_BIT, 2604, clk cycles per UART bit (50 MHz / 19200 baud); must be >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
- ODD_PARITY, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  FIFO can accept a byte; equals !full, combinational from registered state
- tx  output  1  serial line, registered, idles high
- busy  output  1  high while a frame is on the line or the FIFO is non-empty
- fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the frame being shifted

Behaviour:
- Reset (reset==0 at a rising edge):
  - tx=1, busy=0, fifo_count=0, tx_ready=1, FSM=IDLE.
  - FIFO pointers, bit counter and baud counter cleared.
  - Takes priority over everything else.
  - Reset mid-frame aborts the frame: tx=1 after that edge, and all queued bytes are discarded.
- Push: on an edge with tx_valid && tx_ready, tx_data is written at the tail. Push while full never occurs (tx_ready=0); tx_valid is ignored and no data is lost or overwritten.
- Pop:
  - Head is loaded into the shift register when the FSM is in IDLE with FIFO non-empty, or on the last cycle of STOP with FIFO non-empty.
  - Push and pop on the same edge are legal; fifo_count is unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: tx=1. If non-empty: pop, go to START. tx falls on the edge one cycle after a byte enters an empty, idle block.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit 7 go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, pop and go to START if non-empty, else IDLE. No idle gap between queued frames.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
  - Held at 0 in IDLE.
  - Bit counter is 3 bits, wraps 7->0 on exiting DATA.
- Frame length is exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- busy drops on the edge the FSM returns to IDLE with an empty FIFO.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = ^data for even parity, or ~^data when ODD_PARITY=1, held CLKS_PER_BIT cycles. Frame = 11 bits.
- Undefined: no PARITY state, no parity logic, ODD_PARITY unused. Frame = 10 bits.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset held low 3 cycles with tx_valid=1, tx_data=0xFF -> tx=1, busy=0, fifo_count=0, nothing transmitted after release.
- Push 0xA5 into idle block -> tx low 1 cycle later. Line sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. busy=0 after 40 cycles; fifo_count returns to 0 the cycle after acceptance.
- tx_valid held high with bytes 0x00..0x04 on consecutive cycles:
  - All 5 accepted in 5 cycles; fifo_count reaches 4 and tx_ready=0.
  - tx_ready returns to 1 after the first frame's STOP.
  - 5 frames back-to-back in 200 cycles, no idle gap, bytes in order.
- While tx_ready=0, tx_data changes every cycle with tx_valid=1 -> no extra bytes queued; the following frames carry only the accepted bytes.
- Reset asserted at cycle 15 of a frame with 2 bytes queued -> tx=1 next cycle, fifo_count=0, busy=0, no further frames.
- UART_TX_PARITY_EN defined, ODD_PARITY=0:
  - 0xA5 -> parity bit 0, frame 44 cycles.
  - 0x07 -> parity bit 1.
  - With ODD_PARITY=1, 0xA5 -> parity bit 1.
